// File: rtl/alu_exec.sv
// alu_exec: slice-serial ALU with a valid/ready handshake on both sides.
// Operands are latched on accept. One SLICE of the result is produced per CALC
// cycle, starting from the LSB slice, and the carry ripples between slices.
// Optional feature: define ALU_EXEC_OVERFLOW_EN to compute flag_v (signed
// overflow). When it is undefined, flag_v is tied low.
module alu_exec #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc, y_word, logic_word, res_word;
  logic [IW-1:0]    idx;
  logic             carry_q, is_arith, cin0, cin, cout, accept, last;
  logic [SLICE-1:0] a_s, y_s, l_s, slice_out;
  logic [SLICE:0]   sum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (idx == IW'(NSL - 1));

  // Decode the latched op. Arithmetic ops are expressed as a + y + cin. y is
  // b, ~b, 0 (INC) or all-ones (DEC). Logic and pass ops use logic_word.
  always_comb begin
    is_arith   = 1'b0;
    cin0       = 1'b0;
    y_word     = '0;
    logic_word = '0;
    if (op_q[3]) begin
      is_arith = 1'b1;
      y_word   = b_q;
    end else if (op_q[4]) begin
      is_arith = 1'b1;
      y_word   = ~b_q;
      cin0     = 1'b1;
    end else if (op_q[2]) begin
      case (op_q[1:0])
        2'b00:   logic_word = a_q & b_q;
        2'b01:   logic_word = a_q | b_q;
        2'b10:   logic_word = a_q ^ b_q;
        default: logic_word = ~a_q;
      endcase
    end else begin
      case (op_q[1:0])
        2'b00:   logic_word = a_q;
        2'b01:   logic_word = b_q;
        2'b10: begin
          is_arith = 1'b1;
          cin0     = 1'b1;
        end
        default: begin
          is_arith = 1'b1;
          y_word   = '1;
        end
      endcase
    end
  end

  // Slice datapath: select the current slice and add it with the rippled
  // carry. The new slice is merged into the accumulated word.
  always_comb begin
    a_s       = a_q[int'(idx)*SLICE +: SLICE];
    y_s       = y_word[int'(idx)*SLICE +: SLICE];
    l_s       = logic_word[int'(idx)*SLICE +: SLICE];
    cin       = (idx == '0) ? cin0 : carry_q;
    sum       = {1'b0, a_s} + {1'b0, y_s} + {{SLICE{1'b0}}, cin};
    cout      = sum[SLICE];
    slice_out = is_arith ? sum[SLICE-1:0] : l_s;
    res_word  = acc;
    res_word[int'(idx)*SLICE +: SLICE] = slice_out;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic. A result stays in DONE until the consumer takes it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = CALC;
      CALC:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, slice sequencing, and result/flag registration on the last
  // slice. Outputs are only written in CALC, so they hold through DONE stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
      idx  <= '0;
    end else if (state == CALC) begin
      acc     <= res_word;
      carry_q <= cout;
      idx     <= idx + IW'(1);
      if (last) begin
        result <= res_word;
        flag_c <= is_arith & cout;
        flag_z <= (res_word == '0);
        flag_n <= res_word[WIDTH-1];
      end
    end
  end

`ifdef ALU_EXEC_OVERFLOW_EN
  logic c_msb, v_q;
  // Carry into the MSB is recovered from the MSB sum bit and its two inputs.
  assign c_msb = sum[SLICE-1] ^ a_s[SLICE-1] ^ y_s[SLICE-1];

  // Signed overflow, captured on the last slice of arithmetic ops only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      v_q <= 1'b0;
    else if (state == CALC && last) v_q <= is_arith & (c_msb ^ cout);
  end
  assign flag_v = v_q;
`else
  assign flag_v = 1'b0;
`endif

endmodule
